// File: rtl/exc_seq.sv
// Exception entry sequencer: accepts the highest-priority eligible exception
// request and plays out the LR save, SPSR save, CPSR update and PC vector write
// over four consecutive cycles, acking the exception in the last one.
// Optional feature: define HIGH_VECTORS_EN to place the vector table at 0xFFFF0000.
module exc_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  exc_req,
  input  logic [31:0] ret_addr,
  input  logic [31:0] cpsr_in,
  output logic        busy,
  output logic [5:0]  exc_ack,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [4:0]  rf_mode,
  output logic [31:0] rf_wdata,
  output logic        spsr_we,
  output logic [4:0]  spsr_mode,
  output logic [31:0] spsr_wdata,
  output logic        cpsr_we,
  output logic [31:0] cpsr_wdata,
  output logic        flush
);

`ifdef HIGH_VECTORS_EN
  localparam logic [31:0] VecBase = 32'hFFFF_0000;
`else
  localparam logic [31:0] VecBase = 32'h0000_0000;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StSaveLr,
    StSaveSpsr,
    StSetCpsr,
    StSetPc
  } state_e;

  state_e      state_q;
  logic [5:0]  exc_q;    // one-hot accepted exception
  logic [4:0]  mode_q;   // target mode of the accepted exception
  logic [31:0] cpsr_q;   // CPSR captured at acceptance
  logic [31:0] lr_q;     // return address captured at acceptance

  logic [5:0]  elig;
  logic [5:0]  sel;
  logic [4:0]  sel_mode;
  logic [31:0] vec_off;
  logic [31:0] cpsr_new;

  // Pick the winning request and derive per-exception constants.
  always_comb begin
    // IRQ masked by I, FIQ masked by F
    elig = exc_req & ~{1'b0, cpsr_in[6], cpsr_in[7], 3'b000};
    sel  = 6'b000000;
    if (elig[5])      sel = 6'b100000;
    else if (elig[4]) sel = 6'b010000;
    else if (elig[3]) sel = 6'b001000;
    else if (elig[2]) sel = 6'b000100;
    else if (elig[1]) sel = 6'b000010;
    else if (elig[0]) sel = 6'b000001;

    sel_mode = 5'b00000;
    unique case (sel)
      6'b100000: sel_mode = 5'b10111;  // DABT -> ABT
      6'b010000: sel_mode = 5'b10001;  // FIQ
      6'b001000: sel_mode = 5'b10010;  // IRQ
      6'b000100: sel_mode = 5'b10111;  // PABT -> ABT
      6'b000010: sel_mode = 5'b11011;  // UND
      6'b000001: sel_mode = 5'b10011;  // SWI -> SVC
      default:   sel_mode = 5'b00000;
    endcase

    vec_off = 32'h0;
    unique case (exc_q)
      6'b100000: vec_off = 32'h10;
      6'b010000: vec_off = 32'h1C;
      6'b001000: vec_off = 32'h18;
      6'b000100: vec_off = 32'h0C;
      6'b000010: vec_off = 32'h04;
      6'b000001: vec_off = 32'h08;
      default:   vec_off = 32'h0;
    endcase

    // Set I, clear T, force F only for FIQ, switch mode
    cpsr_new = {cpsr_q[31:8], 1'b1, cpsr_q[6] | exc_q[4], 1'b0, mode_q};
  end

  // Sequencer FSM; each output is registered on the edge entering its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      exc_q      <= '0;
      mode_q     <= '0;
      cpsr_q     <= '0;
      lr_q       <= '0;
      exc_ack    <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_mode    <= '0;
      rf_wdata   <= '0;
      spsr_we    <= 1'b0;
      spsr_mode  <= '0;
      spsr_wdata <= '0;
      cpsr_we    <= 1'b0;
      cpsr_wdata <= '0;
      flush      <= 1'b0;
    end else begin
      exc_ack    <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_mode    <= '0;
      rf_wdata   <= '0;
      spsr_we    <= 1'b0;
      spsr_mode  <= '0;
      spsr_wdata <= '0;
      cpsr_we    <= 1'b0;
      cpsr_wdata <= '0;
      flush      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sel != 6'b000000) begin
            state_q  <= StSaveLr;
            exc_q    <= sel;
            mode_q   <= sel_mode;
            cpsr_q   <= cpsr_in;
            lr_q     <= ret_addr;
            rf_we    <= 1'b1;
            rf_waddr <= 4'd14;
            rf_mode  <= sel_mode;
            rf_wdata <= ret_addr;
          end
        end
        StSaveLr: begin
          state_q    <= StSaveSpsr;
          spsr_we    <= 1'b1;
          spsr_mode  <= mode_q;
          spsr_wdata <= cpsr_q;
        end
        StSaveSpsr: begin
          state_q    <= StSetCpsr;
          cpsr_we    <= 1'b1;
          cpsr_wdata <= cpsr_new;
        end
        StSetCpsr: begin
          state_q  <= StSetPc;
          rf_we    <= 1'b1;
          rf_waddr <= 4'd15;
          rf_mode  <= mode_q;
          rf_wdata <= VecBase + vec_off;
          flush    <= 1'b1;
          exc_ack  <= exc_q;
        end
        StSetPc: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_exc_seq.sv
// Self-checking bench for exc_seq: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-queue reference model.
module tb_exc_seq;

`ifdef HIGH_VECTORS_EN
  localparam logic [31:0] VBase = 32'hFFFF_0000;
`else
  localparam logic [31:0] VBase = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  exc_req;
  logic [31:0] ret_addr;
  logic [31:0] cpsr_in;
  logic        busy;
  logic [5:0]  exc_ack;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [4:0]  rf_mode;
  logic [31:0] rf_wdata;
  logic        spsr_we;
  logic [4:0]  spsr_mode;
  logic [31:0] spsr_wdata;
  logic        cpsr_we;
  logic [31:0] cpsr_wdata;
  logic        flush;

  always #5 clk = ~clk;

  exc_seq dut (
    .clk        (clk),
    .rst        (rst),
    .exc_req    (exc_req),
    .ret_addr   (ret_addr),
    .cpsr_in    (cpsr_in),
    .busy       (busy),
    .exc_ack    (exc_ack),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_mode    (rf_mode),
    .rf_wdata   (rf_wdata),
    .spsr_we    (spsr_we),
    .spsr_mode  (spsr_mode),
    .spsr_wdata (spsr_wdata),
    .cpsr_we    (cpsr_we),
    .cpsr_wdata (cpsr_wdata),
    .flush      (flush)
  );

  typedef struct packed {
    logic        busy;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [4:0]  rf_mode;
    logic [31:0] rf_wdata;
    logic        spsr_we;
    logic [4:0]  spsr_mode;
    logic [31:0] spsr_wdata;
    logic        cpsr_we;
    logic [31:0] cpsr_wdata;
    logic        flush;
    logic [5:0]  exc_ack;
  } obs_t;

  typedef struct {
    logic [5:0]  req;
    logic [31:0] cpsr;
    logic [31:0] ret;
    logic [4:0]  mode;
    logic [31:0] cpsr_exp;
    logic [31:0] off;
    logic [5:0]  ack;
  } vec_t;

  obs_t act;
  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always_comb act = {busy, rf_we, rf_waddr, rf_mode, rf_wdata, spsr_we, spsr_mode, spsr_wdata,
                     cpsr_we, cpsr_wdata, flush, exc_ack};

  function automatic logic [4:0] mode_for(int idx);
    case (idx)
      5: return 5'b10111;
      4: return 5'b10001;
      3: return 5'b10010;
      2: return 5'b10111;
      1: return 5'b11011;
      default: return 5'b10011;
    endcase
  endfunction

  function automatic logic [31:0] off_for(int idx);
    case (idx)
      5: return 32'h10;
      4: return 32'h1C;
      3: return 32'h18;
      2: return 32'h0C;
      1: return 32'h04;
      default: return 32'h08;
    endcase
  endfunction

  task automatic check_obs(string name, obs_t a, obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic check_val(string name, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  // Reference model: when idle, the highest eligible request becomes a
  // five-entry transaction (four write cycles plus the return-to-idle cycle).
  task automatic model_accept();
    int   win;
    obs_t r;
    logic [31:0] c;
    logic [4:0]  m;
    if (exp_q.size() != 0) return;
    win = -1;
    for (int i = 5; i >= 0; i--) begin
      if (win < 0 && exc_req[i] && !(i == 3 && cpsr_in[7]) && !(i == 4 && cpsr_in[6])) win = i;
    end
    if (win < 0) return;
    m = mode_for(win);
    r = '0; r.busy = 1'b1; r.rf_we = 1'b1; r.rf_waddr = 4'd14; r.rf_mode = m;
    r.rf_wdata = ret_addr;
    exp_q.push_back(r);
    r = '0; r.busy = 1'b1; r.spsr_we = 1'b1; r.spsr_mode = m; r.spsr_wdata = cpsr_in;
    exp_q.push_back(r);
    c = cpsr_in; c[4:0] = m; c[5] = 1'b0; c[7] = 1'b1;
    if (win == 4) c[6] = 1'b1;
    r = '0; r.busy = 1'b1; r.cpsr_we = 1'b1; r.cpsr_wdata = c;
    exp_q.push_back(r);
    r = '0; r.busy = 1'b1; r.rf_we = 1'b1; r.rf_waddr = 4'd15; r.rf_mode = m;
    r.rf_wdata = VBase + off_for(win); r.flush = 1'b1; r.exc_ack = 6'(1 << win);
    exp_q.push_back(r);
    exp_q.push_back('0);
  endtask

  // One clock: model decision, edge, compare, requester drops acked bit.
  task automatic cycle();
    obs_t e;
    model_accept();
    @(posedge clk);
    #1;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check_obs("seq", act, e);
    exc_req = exc_req & ~e.exc_ack;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    check_obs("async_rst", act, '0);
    exp_q.delete();
    rst = 1'b0;
  endtask

  vec_t       vecs[7];
  obs_t       cap[5];
  logic [5:0] acks[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{6'b001000, 32'h0000_0010, 32'h0000_0100, 5'h12, 32'h0000_0092, 32'h18, 6'b001000};
    vecs[1] = '{6'b010000, 32'h0000_0013, 32'h0000_2000, 5'h11, 32'h0000_00D1, 32'h1C, 6'b010000};
    vecs[2] = '{6'b100000, 32'h0000_0030, 32'h0000_0044, 5'h17, 32'h0000_0097, 32'h10, 6'b100000};
    vecs[3] = '{6'b000100, 32'hF000_0053, 32'h0000_0008, 5'h17, 32'hF000_00D7, 32'h0C, 6'b000100};
    vecs[4] = '{6'b000010, 32'h0000_001F, 32'h0000_ABCD, 5'h1B, 32'h0000_009B, 32'h04, 6'b000010};
    vecs[5] = '{6'b000001, 32'h0000_0010, 32'hCAFE_0000, 5'h13, 32'h0000_0093, 32'h08, 6'b000001};
    vecs[6] = '{6'b011000, 32'h0000_0040, 32'h0000_1234, 5'h12, 32'h0000_00D2, 32'h18, 6'b001000};

    rst = 1'b1; exc_req = '0; cpsr_in = 32'h10; ret_addr = '0;
    #2;
    check_obs("reset_state", act, '0);
    // Request present at reset release is accepted on the first edge
    exc_req = vecs[0].req; cpsr_in = vecs[0].cpsr; ret_addr = vecs[0].ret;
    #1 rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      exc_req = vecs[v].req; cpsr_in = vecs[v].cpsr; ret_addr = vecs[v].ret;
      for (int k = 0; k < 5; k++) begin
        if (k == 4) exc_req = '0;
        cycle();
        cap[k] = act;
        // Inputs changing after acceptance must not disturb the sequence
        if (k == 0) begin cpsr_in = $urandom; ret_addr = $urandom; end
      end
      check_val("vec_lr", {cap[0].rf_we, cap[0].rf_waddr, cap[0].rf_mode, cap[0].rf_wdata},
                {1'b1, 4'd14, vecs[v].mode, vecs[v].ret});
      check_val("vec_spsr", {cap[1].spsr_we, cap[1].spsr_mode, cap[1].spsr_wdata},
                {1'b1, vecs[v].mode, vecs[v].cpsr});
      check_val("vec_cpsr", {cap[2].cpsr_we, cap[2].cpsr_wdata}, {1'b1, vecs[v].cpsr_exp});
      check_val("vec_pc", {cap[3].rf_waddr, cap[3].rf_wdata, cap[3].flush, cap[3].exc_ack},
                {4'd15, VBase + vecs[v].off, 1'b1, vecs[v].ack});
      check_val("vec_idle", {cap[4].busy, cap[4].exc_ack}, '0);
    end

    // All six requested at once: served in priority order
    cpsr_in = 32'h10; ret_addr = 32'h40; exc_req = 6'b111111;
    for (int i = 0; i < 40 && acks.size() < 6; i++) begin
      cycle();
      if (act.exc_ack != 0) acks.push_back(act.exc_ack);
    end
    check_val("all6_count", 64'(acks.size()), 64'd6);
    for (int k = 0; k < 6 && k < acks.size(); k++)
      check_val("all6_order", {58'd0, acks[k]}, {58'd0, 6'(6'b100000 >> k)});
    drain();

    // IRQ masked by I stays pending, starts on the edge after unmasking
    cpsr_in = 32'h90; exc_req = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_val("irq_masked_busy", {63'd0, busy}, 64'd0);
    end
    cpsr_in = 32'h10;
    cycle();
    check_val("irq_unmask_start", {busy, rf_we, rf_waddr, rf_mode}, {1'b1, 1'b1, 4'd14, 5'h12});
    drain();

    // Reset during SET_CPSR abandons the sequence; held request restarts
    exc_req = 6'b000001; cpsr_in = 32'h10; ret_addr = 32'h500;
    cycle(); cycle(); cycle();
    check_val("rst_mid_in_cpsr", {63'd0, cpsr_we}, 64'd1);
    #1 async_reset();
    cycle();
    check_val("rst_restart", {busy, rf_waddr, rf_wdata}, {1'b1, 4'd14, 32'h500});
    drain();

    // UND raised during SWI's SAVE_LR waits for the next idle cycle
    exc_req = 6'b000001; cpsr_in = 32'h10; ret_addr = 32'h600;
    cycle();
    exc_req = exc_req | 6'b000010;
    cycle(); cycle(); cycle();
    check_val("swi_pc", {rf_wdata, exc_ack}, {VBase + 32'h08, 6'b000001});
    cycle();
    cycle();
    check_val("und_next", {busy, rf_waddr, rf_mode}, {1'b1, 4'd14, 5'b11011});
    drain();

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        #1 async_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) exc_req = exc_req | 6'(1 << $urandom_range(0, 5));
        cpsr_in = $urandom;
        ret_addr = $urandom;
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_seq.md
EXC_SEQ -- requirements
Module: exc_seq

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL: exc_req  input  6  level requests {[5] DABT, [4] FIQ, [3] IRQ, [2] PABT, [1] UND, [0] SWI}; held by the requester until its ack.
REQ-004 SHALL: ret_addr  input  32  return address for the banked LR, sampled at acceptance.
REQ-005 SHALL: cpsr_in  input  32  current CPSR, sampled at acceptance; [7]=I, [6]=F, [5]=T, [4:0]=mode.
REQ-006 SHALL: busy  output  1  high while a sequence is in progress.
REQ-007 SHALL: exc_ack  output  6  one-hot, one-cycle pulse for the completed exception, with the same bit order as exc_req.
REQ-008 SHALL: rf_we, rf_waddr[3:0], rf_mode[4:0], rf_wdata[31:0]  outputs  register-file write port (logical address plus mode, resolved by the regfile address map).
REQ-009 SHALL: spsr_we, spsr_mode[4:0], spsr_wdata[31:0]  outputs  SPSR write port.
REQ-010 SHALL: cpsr_we, cpsr_wdata[31:0]  outputs  CPSR write port.
REQ-011 SHALL: flush  output  1  one-cycle pipeline flush pulse.

Function
REQ-012 SHALL: the FSM states are IDLE, SAVE_LR, SAVE_SPSR, SET_CPSR and SET_PC; each non-IDLE state lasts exactly one cycle, in that order, then returns to IDLE.
REQ-013 SHALL: in IDLE, an exception is eligible when its request bit is set, except that IRQ is ineligible when cpsr_in[7]=1 and FIQ is ineligible when cpsr_in[6]=1.
REQ-014 SHALL: with any eligible request present in IDLE, the FSM accepts the highest-priority one (DABT > FIQ > IRQ > PABT > UND > SWI), latches the exception, cpsr_in and ret_addr, and enters SAVE_LR on the next edge.
REQ-015 SHALL: target mode per exception: DABT/PABT = ABT 5'b10111; FIQ 5'b10001; IRQ 5'b10010; UND 5'b11011; SWI = SVC 5'b10011.
REQ-016 SHALL: in SAVE_LR: rf_we=1, rf_waddr=14, rf_mode=target mode, rf_wdata=latched ret_addr.
REQ-017 SHALL: in SAVE_SPSR: spsr_we=1, spsr_mode=target mode, spsr_wdata=latched CPSR.
REQ-018 SHALL: in SET_CPSR: cpsr_we=1; cpsr_wdata equals the latched CPSR with [4:0]=target mode, [5]=0 and [7]=1; [6] is forced to 1 for FIQ, otherwise it keeps its latched value.
REQ-019 SHALL: in SET_PC: rf_we=1, rf_waddr=15, rf_mode=target mode, rf_wdata=vector base + offset (UND 0x04, SWI 0x08, PABT 0x0C, DABT 0x10, IRQ 0x18, FIQ 0x1C); flush=1; exc_ack asserts the accepted bit.
REQ-020 SHALL: busy=1 exactly in SAVE_LR through SET_PC, giving a latency of 4 cycles from acceptance to ack.
REQ-021 SHALL: exc_req is not sampled while busy; requests arriving mid-sequence, including higher-priority ones, wait for IDLE.
REQ-022 SHALL: changes to cpsr_in or ret_addr after acceptance have no effect on the current sequence.
REQ-023 SHALL: outside the states listed above, every strobe (rf_we, spsr_we, cpsr_we, flush, exc_ack) is 0, and data/address outputs are 0.
REQ-024 SHALL: the earliest next acceptance is the IDLE cycle immediately after SET_PC; a request bit still high then is treated as a new exception.

Reset
REQ-025 SHALL: asserting rst forces the FSM to IDLE and all outputs and latches to 0 immediately, without waiting for clk.
REQ-026 SHALL: reset asserted mid-sequence abandons the sequence with no further strobes and no ack.
REQ-027 SHALL: after rst deasserts, the first possible acceptance is at the first rising edge.

Configuration
REQ-028 SHALL: with HIGH_VECTORS_EN defined, the vector base is 32'hFFFF0000; with it undefined, the vector base is 32'h00000000; nothing else changes.

Verification
REQ-029 SHALL: IRQ with cpsr_in=0x00000010 and ret_addr=0x100 -> the bench sees LR write (addr 14, mode 0x12, data 0x100), then SPSR write 0x10, then CPSR write 0x92, then PC write 0x18 with flush and exc_ack=6'b001000, all 4 cycles from acceptance.
REQ-030 SHALL: exc_req=6'b111111 with cpsr_in=0x10 -> DABT is served first (PC write 0x10, mode 0x17), then FIQ, IRQ, PABT, UND and SWI in order as the requester drops each acked bit.
REQ-031 SHALL: IRQ with cpsr_in[7]=1 -> the request stays pending with busy=0; after cpsr_in[7] is cleared, the sequence starts on the next edge.
REQ-032 SHALL: FIQ with cpsr_in=0x13 -> CPSR write 0xD1 and PC write 0x1C (0xFFFF001C with HIGH_VECTORS_EN defined).
REQ-033 SHALL: rst pulsed during SET_CPSR -> no PC write, no ack, busy=0; the still-held request restarts from SAVE_LR.
REQ-034 SHALL: SWI accepted, then UND raised during SAVE_LR -> SWI completes unaffected (PC 0x08), and UND is accepted in the following IDLE cycle.
